// File: rtl/booth4_csa_accum.sv
// Iterative unsigned radix-4 Booth multiplier front-end: one Booth digit per
// clock is folded into a carry-save accumulator; the two rows feed a 2N-bit CPA.
module booth4_csa_accum #(
   parameter int N = 16
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [N-1:0]   in_a,
   input  logic [N-1:0]   in_b,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [2*N-1:0] out_sum,
   output logic [2*N-1:0] out_carry,
   output logic           busy
);

   localparam int DIG = N / 2 + 1;
   localparam int W   = 2 * N;
   localparam int CW  = $clog2(DIG + 1);

   // Handshakes: a transfer happens on a rising edge where valid && ready.
   // in_ready and out_valid decode only from the state register, so neither
   // depends combinationally on in_valid or out_ready.
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t        state;
   logic [CW-1:0] cnt;
   logic [N-1:0]  x;
   logic [N-1:0]  y;
   logic [W-1:0]  sum_r;
   logic [W-1:0]  carry_r;

   // Extra zero padding on top keeps the digit select in range once cnt
   // has moved past the last digit.
   logic [N+4:0]  y_ext;
   int unsigned   shamt;
   logic [2:0]    trip;
   logic          neg;
   logic          mag1;
   logic          mag2;
   logic [W-1:0]  mult;
   logic [W-1:0]  m_shift;
   logic [W-1:0]  pp;
   logic [W-1:0]  sum_nxt;
   logic [W-2:0]  maj;
   logic [W-1:0]  carry_nxt;

   always_comb begin
      y_ext = {4'b0000, y, 1'b0};
      shamt = 2 * int'(cnt);
      trip  = y_ext[shamt +: 3];
      neg   = 1'b0;
      mag1  = 1'b0;
      mag2  = 1'b0;
      case (trip)
         3'b001, 3'b010: mag1 = 1'b1;
         3'b011:         mag2 = 1'b1;
         3'b100:         begin mag2 = 1'b1; neg = 1'b1; end
         3'b101, 3'b110: begin mag1 = 1'b1; neg = 1'b1; end
         default:        ;
      endcase
      if (mag2)
         mult = {{(N-1){1'b0}}, x, 1'b0};
      else if (mag1)
         mult = {{N{1'b0}}, x};
      else
         mult = '0;
      m_shift = mult << shamt;
      pp      = neg ? ~m_shift : m_shift;
      // 3:2 compressor row; neg enters as the +1 of the two's complement.
      sum_nxt   = sum_r ^ carry_r ^ pp;
      maj       = (sum_r[W-2:0] & carry_r[W-2:0]) |
                  (sum_r[W-2:0] & pp[W-2:0]) |
                  (carry_r[W-2:0] & pp[W-2:0]);
      carry_nxt = {maj, neg};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         cnt     <= '0;
         x       <= '0;
         y       <= '0;
         sum_r   <= '0;
         carry_r <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  x       <= in_a;
                  y       <= in_b;
                  sum_r   <= '0;
                  carry_r <= '0;
                  cnt     <= '0;
                  state   <= RUN;
               end
            end
            RUN: begin
               sum_r   <= sum_nxt;
               carry_r <= carry_nxt;
               cnt     <= cnt + 1'b1;
               if (cnt == CW'(DIG - 1))
                  state <= DONE;
            end
            DONE: begin
               if (out_ready)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign busy      = (state != IDLE);
   assign out_sum   = sum_r;
   assign out_carry = carry_r;

endmodule

// File: tb/tb_booth4_csa_accum.sv
// Directed bench for booth4_csa_accum: latency, Booth corner cases, stall,
// ignored inputs while busy, mid-run reset and a CPA-model operand sweep.
module tb_booth4_csa_accum;

   localparam int N = 16;
   localparam int W = 2 * N;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [N-1:0] in_a = '0;
   logic [N-1:0] in_b = '0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [W-1:0] out_sum;
   logic [W-1:0] out_carry;
   logic         busy;

   int n_checks = 0;
   int n_pass   = 0;

   booth4_csa_accum #(.N(N)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum),
      .out_carry (out_carry),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   // Drive one operand pair; returns once the accept edge has passed.
   task automatic start_op(input logic [N-1:0] a, input logic [N-1:0] b);
      int guard;
      guard = 0;
      @(negedge clk);
      while (!in_ready && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      in_a     = a;
      in_b     = b;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   // Count edges after the accept edge until out_valid, bounded.
   task automatic wait_done(output int cycles);
      cycles = 0;
      while (!out_valid && cycles < 40) begin
         @(posedge clk);
         #1;
         cycles++;
      end
   endtask

   task automatic release_result();
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      n_checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b exp=1", in_ready); else n_pass++;
      n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b exp=0", out_valid); else n_pass++;
      n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else n_pass++;
      n_checks++; if (out_sum !== '0) $display("FAIL reset_sum got=%h exp=0", out_sum); else n_pass++;
      n_checks++; if (out_carry !== '0) $display("FAIL reset_carry got=%h exp=0", out_carry); else n_pass++;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_small();
      int cyc;
      logic [W-1:0] rows;
      out_ready = 1'b1;
      start_op(16'd3, 16'd5);
      wait_done(cyc);
      rows = out_sum + out_carry;
      n_checks++; if (cyc !== 9) $display("FAIL small_latency got=%0d exp=9", cyc); else n_pass++;
      n_checks++; if (rows !== 32'h0000000F) $display("FAIL small_rows got=%h exp=0000000f", rows); else n_pass++;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      n_checks++; if (in_ready !== 1'b1) $display("FAIL small_in_ready_after got=%b exp=1", in_ready); else n_pass++;
      n_checks++; if (busy !== 1'b0) $display("FAIL small_busy_after got=%b exp=0", busy); else n_pass++;
   endtask

   task automatic test_negative_digits();
      int cyc;
      logic [W-1:0] rows;
      start_op(16'hFFFF, 16'hFFFF);
      wait_done(cyc);
      rows = out_sum + out_carry;
      n_checks++; if (rows !== 32'hFFFE0001) $display("FAIL neg_rows got=%h exp=fffe0001", rows); else n_pass++;
      n_checks++; if (cyc !== 9) $display("FAIL neg_latency got=%0d exp=9", cyc); else n_pass++;
      release_result();
   endtask

   task automatic test_zero_stall();
      int cyc;
      logic [W-1:0] rows;
      logic [W-1:0] s0;
      logic [W-1:0] c0;
      start_op(16'h1234, 16'h0000);
      wait_done(cyc);
      rows = out_sum + out_carry;
      n_checks++; if (rows !== 32'h0) $display("FAIL zero_b_rows got=%h exp=0", rows); else n_pass++;
      release_result();
      start_op(16'h0000, 16'hBEEF);
      wait_done(cyc);
      rows = out_sum + out_carry;
      n_checks++; if (rows !== 32'h0) $display("FAIL zero_a_rows got=%h exp=0", rows); else n_pass++;
      s0 = out_sum;
      c0 = out_carry;
      for (int k = 0; k < 5; k++) begin
         @(posedge clk);
         #1;
         n_checks++; if (out_valid !== 1'b1) $display("FAIL stall_valid cyc=%0d got=%b exp=1", k, out_valid); else n_pass++;
         n_checks++; if (out_sum !== s0) $display("FAIL stall_sum cyc=%0d got=%h exp=%h", k, out_sum, s0); else n_pass++;
         n_checks++; if (out_carry !== c0) $display("FAIL stall_carry cyc=%0d got=%h exp=%h", k, out_carry, c0); else n_pass++;
      end
      release_result();
      n_checks++; if (in_ready !== 1'b1) $display("FAIL stall_in_ready_after got=%b exp=1", in_ready); else n_pass++;
   endtask

   task automatic test_busy_ignore();
      int cyc;
      logic [W-1:0] rows;
      start_op(16'h00AB, 16'h0100);
      @(negedge clk);
      in_a     = 16'd7;
      in_b     = 16'd7;
      in_valid = 1'b1;
      repeat (2) begin
         @(posedge clk);
         #1;
         n_checks++; if (in_ready !== 1'b0) $display("FAIL busy_in_ready got=%b exp=0", in_ready); else n_pass++;
      end
      in_valid = 1'b0;
      wait_done(cyc);
      rows = out_sum + out_carry;
      n_checks++; if (rows !== 32'h0000AB00) $display("FAIL busy_rows got=%h exp=0000ab00", rows); else n_pass++;
      release_result();
   endtask

   task automatic test_mid_reset();
      int cyc;
      logic [W-1:0] rows;
      start_op(16'h1234, 16'h5678);
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #2;
      n_checks++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid got=%b exp=0", out_valid); else n_pass++;
      n_checks++; if (busy !== 1'b0) $display("FAIL rst_busy got=%b exp=0", busy); else n_pass++;
      n_checks++; if (in_ready !== 1'b1) $display("FAIL rst_in_ready got=%b exp=1", in_ready); else n_pass++;
      n_checks++; if (out_sum !== '0) $display("FAIL rst_sum got=%h exp=0", out_sum); else n_pass++;
      n_checks++; if (out_carry !== '0) $display("FAIL rst_carry got=%h exp=0", out_carry); else n_pass++;
      @(negedge clk);
      rst_n = 1'b1;
      start_op(16'h8000, 16'h8000);
      wait_done(cyc);
      rows = out_sum + out_carry;
      n_checks++; if (rows !== 32'h40000000) $display("FAIL rst_new_rows got=%h exp=40000000", rows); else n_pass++;
      release_result();
   endtask

   // Downstream CPA model: 33-bit add of the two rows, carry-out dropped.
   task automatic test_sweep();
      int cyc;
      logic [W:0]   cpa;
      logic [W-1:0] a32;
      logic [W-1:0] b32;
      logic [W-1:0] exp_p;
      logic [N-1:0] a;
      logic [N-1:0] b;
      for (int t = 0; t < 300; t++) begin
         a = N'($urandom_range(0, 65535));
         b = N'($urandom_range(0, 65535));
         if (t == 0) begin a = 16'hFFFF; b = 16'hAAAA; end
         if (t == 1) begin a = 16'h5555; b = 16'hFFFF; end
         a32   = {16'h0, a};
         b32   = {16'h0, b};
         exp_p = a32 * b32;
         start_op(a, b);
         wait_done(cyc);
         cpa = {1'b0, out_sum} + {1'b0, out_carry};
         n_checks++;
         if (cpa[W-1:0] !== exp_p)
            $display("FAIL sweep_cpa a=%h b=%h got=%h exp=%h", a, b, cpa[W-1:0], exp_p);
         else
            n_pass++;
         release_result();
      end
   endtask

   initial begin
      test_reset();
      test_small();
      test_negative_digits();
      test_zero_stall();
      test_busy_ignore();
      test_mid_reset();
      test_sweep();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
